// File: rtl/cordic_arbiter_if.sv
// cordic_arbiter_if: request, CORDIC and response signals shared by two requesters and one CORDIC
// Ports: slave modport is the arbiter side, master modport is the requester/CORDIC side
interface cordic_arbiter_if #(parameter int W = 20);
    logic         req0_valid;
    logic [W-1:0] req0_angle;
    logic         req0_ready;
    logic         req1_valid;
    logic [W-1:0] req1_angle;
    logic         req1_ready;
    logic [W-1:0] cordic_g;
    logic [W-1:0] cordic_z;
    logic         rsp0_valid;
    logic [W-1:0] rsp0_data;
    logic         rsp1_valid;
    logic [W-1:0] rsp1_data;
    logic         busy;
    modport slave (
        input  req0_valid, req0_angle, req1_valid, req1_angle, cordic_z,
        output req0_ready, req1_ready, cordic_g, rsp0_valid, rsp0_data, rsp1_valid, rsp1_data, busy
    );
    modport master (
        output req0_valid, req0_angle, req1_valid, req1_angle, cordic_z,
        input  req0_ready, req1_ready, cordic_g, rsp0_valid, rsp0_data, rsp1_valid, rsp1_data, busy
    );
endinterface

// File: rtl/cordic_arbiter.sv
// cordic_arbiter: round-robin sharing of one pipelined CORDIC between two requesters
// Ports: clk, reset (sync, active-high); bus (slave) carries req0/req1 valid/angle/ready,
// cordic_g/cordic_z to the shared CORDIC, rsp0/rsp1 valid/data results and busy
module cordic_arbiter #(
    parameter int W   = 20,
    parameter int LAT = 16
) (
    input logic            clk,
    input logic            reset,
    cordic_arbiter_if.slave bus
);
    logic         last;
    logic [LAT:0] tag_v;
    logic [LAT:0] tag_id;
    logic         g0;
    logic         g1;
    // a tie goes to the requester that did not win the most recent accept
    assign g0 = !reset && bus.req0_valid && (!bus.req1_valid || last);
    assign g1 = !reset && bus.req1_valid && (!bus.req0_valid || !last);
    assign bus.req0_ready = g0;
    assign bus.req1_ready = g1;
    always_ff @(posedge clk) begin
        if (reset) begin
            last           <= 1'b1;
            tag_v          <= '0;
            tag_id         <= '0;
            bus.cordic_g   <= '0;
            bus.rsp0_valid <= 1'b0;
            bus.rsp1_valid <= 1'b0;
            bus.rsp0_data  <= '0;
            bus.rsp1_data  <= '0;
            bus.busy       <= 1'b0;
        end else begin
            last           <= g1 ? 1'b1 : g0 ? 1'b0 : last;
            bus.cordic_g   <= g0 ? bus.req0_angle : g1 ? bus.req1_angle : '0;
            tag_v          <= {tag_v[LAT-1:0], g0 | g1};
            tag_id         <= {tag_id[LAT-1:0], g1};
            bus.rsp0_valid <= tag_v[LAT] && !tag_id[LAT];
            bus.rsp1_valid <= tag_v[LAT] && tag_id[LAT];
            bus.rsp0_data  <= (tag_v[LAT] && !tag_id[LAT]) ? bus.cordic_z : bus.rsp0_data;
            bus.rsp1_data  <= (tag_v[LAT] && tag_id[LAT]) ? bus.cordic_z : bus.rsp1_data;
            bus.busy       <= |tag_v;
        end
    end
endmodule

// File: tb/tb_cordic_arbiter.sv
// tb_cordic_arbiter: scoreboard bench for cordic_arbiter with an identity LAT-stage CORDIC model
module tb_cordic_arbiter;
    localparam int W = 20;
    localparam int LAT = 16;
    typedef struct {
        int           id;
        logic [W-1:0] ang;
        int           due;
    } item_t;
    logic clk = 0;
    logic reset = 1;
    logic run = 0;
    logic force5 = 0;
    int cyc = 0;
    int n_tests = 0;
    int n_fail = 0;
    int last_id = 1;
    logic [W-1:0] exp_d0 = '0;
    logic [W-1:0] exp_d1 = '0;
    logic [W-1:0] pipe [LAT];
    item_t q[$];
    item_t mon_e;
    logic mon_busy;
    cordic_arbiter_if #(.W(W)) bus ();
    cordic_arbiter #(.W(W), .LAT(LAT)) dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    // identity CORDIC: z is g delayed by LAT stages; optionally bubbles come out as 5
    always @(posedge clk) begin
        pipe[0] <= (force5 && bus.cordic_g == '0) ? W'(5) : bus.cordic_g;
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign bus.cordic_z = pipe[LAT-1];
    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", nm, act, exp, cyc);
        end
    endtask
    // one clock cycle of stimulus; called at a falling edge
    task automatic drive(input logic r, input logic v0, input logic [W-1:0] a0,
                         input logic v1, input logic [W-1:0] a1);
        int gid;
        logic [W-1:0] ga;
        reset = r;
        bus.req0_valid = v0;
        bus.req0_angle = a0;
        bus.req1_valid = v1;
        bus.req1_angle = a1;
        gid = -1;
        if (!r) gid = (v0 && v1) ? 1 - last_id : v0 ? 0 : v1 ? 1 : -1;
        ga = gid == 0 ? a0 : gid == 1 ? a1 : '0;
        #1;
        check("req0_ready", 32'(bus.req0_ready), 32'(gid == 0));
        check("req1_ready", 32'(bus.req1_ready), 32'(gid == 1));
        if (gid >= 0) begin
            q.push_back(item_t'{gid, ga, cyc + LAT + 2});
            last_id = gid;
        end
        @(posedge clk);
        if (r) begin
            q.delete();
            last_id = 1;
            exp_d0 = '0;
            exp_d1 = '0;
        end
        @(negedge clk);
        check("cordic_g", 32'(bus.cordic_g), 32'(ga));
    endtask
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, '0, 0, '0);
    endtask
    always @(negedge clk) begin
        if (run) begin
            mon_busy = 1'b0;
            foreach (q[i]) if (cyc >= q[i].due - LAT && cyc <= q[i].due) mon_busy = 1'b1;
            check("busy", 32'(bus.busy), 32'(mon_busy));
            check("rsp_both", 32'(bus.rsp0_valid & bus.rsp1_valid), 0);
            if (bus.rsp0_valid || bus.rsp1_valid) begin
                if (q.size() == 0) check("rsp_unexpected", 32'(bus.rsp0_valid | bus.rsp1_valid), 0);
                else begin
                    mon_e = q.pop_front();
                    check("rsp_id", 32'(bus.rsp1_valid), 32'(mon_e.id));
                    check("rsp_cycle", 32'(cyc), 32'(mon_e.due));
                    check("rsp_data", 32'(bus.rsp1_valid ? bus.rsp1_data : bus.rsp0_data), 32'(mon_e.ang));
                    if (mon_e.id == 1) exp_d1 = mon_e.ang;
                    else exp_d0 = mon_e.ang;
                end
            end else if (q.size() != 0 && q[0].due <= cyc) begin
                check("rsp_missing", 32'(bus.rsp0_valid | bus.rsp1_valid), 1);
                void'(q.pop_front());
            end
            check("rsp0_data_hold", 32'(bus.rsp0_data), 32'(exp_d0));
            check("rsp1_data_hold", 32'(bus.rsp1_data), 32'(exp_d1));
        end
    end
    logic [W-1:0] tie0 [8];
    logic [W-1:0] tie1 [8];
    logic [W-1:0] strm [14];
    initial begin
        bus.req0_valid = 0;
        bus.req0_angle = '0;
        bus.req1_valid = 0;
        bus.req1_angle = '0;
        @(negedge clk);
        drive(1, 1, W'(5), 1, W'(7));
        drive(1, 1, W'(9), 1, W'(3));
        run = 1;
        drive(0, 1, W'(262144), 0, '0);
        idle(LAT + 4);
        for (int i = 0; i < 8; i++) begin
            tie0[i] = i == 0 ? W'(786432) : i == 1 ? W'(795365) : W'($urandom());
            tie1[i] = i == 0 ? W'(0) : i == 1 ? W'(67848) : W'($urandom());
        end
        for (int i = 0; i < 8; i++) drive(0, 1, tie0[i], 1, tie1[i]);
        idle(LAT + 4);
        for (int i = 0; i < 14; i++)
            strm[i] = i == 0 ? W'(786432) : i == 12 ? W'(262144) : i == 13 ? W'(1) : W'($urandom());
        for (int i = 0; i < 14; i++) drive(0, 0, '0, 1, strm[i]);
        idle(LAT + 4);
        force5 = 1;
        for (int i = 0; i < 12; i++) drive(0, 1'(i % 2 == 0), W'(131072), 0, '0);
        idle(LAT + 4);
        force5 = 0;
        for (int i = 0; i < 5; i++) drive(0, 1, W'($urandom()), 0, '0);
        idle(2);
        drive(1, 0, '0, 0, '0);
        idle(LAT + 4);
        drive(0, 1, W'(1234), 1, W'(4321));
        drive(0, 1, W'(1111), 1, W'(2222));
        idle(LAT + 4);
        for (int i = 0; i < 300; i++)
            drive(1'($urandom_range(0, 39) == 0), 1'($urandom_range(0, 1)), W'($urandom()),
                  1'($urandom_range(0, 1)), W'($urandom()));
        idle(LAT + 6);
        check("drain", 32'(q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/cordic_arbiter.md
CORDIC_ARBITER -- requirements
Module: cordic_arbiter

Interface
REQ-001 Parameter W, default 20, meaning angle/result width; angles are binary angles (2^(W-2) = +pi/2, two's complement; e.g. 20'd262144 = +pi/2, 20'd786432 = -pi/2).
REQ-002 Parameter LAT, default 16, meaning the pipelined CORDIC latency in clk edges from sampling g to a valid z.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req0_valid  input  1  requester 0 has an angle to issue.
REQ-006 req0_angle  input  W  requester 0 angle.
REQ-007 req0_ready  output  1  requester 0 accepted this cycle (combinational grant).
REQ-008 req1_valid, req1_angle, req1_ready  same as REQ-005..007 for requester 1.
REQ-009 cordic_g  output  W  registered angle driven to the shared CORDIC g input.
REQ-010 cordic_z  input  W  CORDIC z_out result.
REQ-011 rsp0_valid  output  1  one-cycle pulse, result for requester 0.
REQ-012 rsp0_data  output  W  result for requester 0, valid only with rsp0_valid.
REQ-013 rsp1_valid, rsp1_data  same as REQ-011..012 for requester 1.
REQ-014 busy  output  1  high while any issued angle is in flight.

Function
REQ-015 Accept = reqN_valid & reqN_ready; at most one accept per cycle; no backpressure on rsp outputs.
REQ-016 Round-robin: with one valid, grant it; with both valid, grant the requester not granted by the most recent accept; after reset, requester 0 wins the first tie.
REQ-017 reqN_ready depends only on current valids and the last-grant pointer; pointer updates only on an accept.
REQ-018 On accept at edge E0, cordic_g takes the granted angle at E0; on a cycle with no accept, cordic_g is 0 (bubble).
REQ-019 A tag shift register of depth LAT+1 carries {issued, requester id}; it advances every cycle, with no stall.
REQ-020 At edge E0+LAT+1, cordic_z is captured into rspN_data of the tagged requester and rspN_valid pulses for exactly one cycle; the other requester's valid stays 0 and its data holds.
REQ-021 Back-to-back accepts every cycle yield back-to-back rsp pulses in issue order, with no drops or reordering; throughput is 1 result/cycle.
REQ-022 Bubble cycles produce no rsp pulse, even if cordic_z is nonzero.
REQ-023 busy = OR of the tag-register issued bits, registered; it falls in the cycle after the last rsp pulse.
REQ-024 Alternating grants with both requesters permanently valid: grants go 0,1,0,1,...; per-requester results stay in that requester's issue order.
REQ-025 Arithmetic: angles and results pass through unmodified; there is no width change or sign handling inside the block.

Reset
REQ-026 While reset=1 at an edge: cordic_g=0, rsp0_valid=rsp1_valid=0, rsp0_data=rsp1_data=0, busy=0, all tags cleared, last-grant pointer = requester 1 (so requester 0 wins the first tie).
REQ-027 While reset=1, req0_ready=req1_ready=0.
REQ-028 Reset mid-operation discards all in-flight tags; no rsp pulse occurs for angles issued before reset, even though the CORDIC pipeline still holds them.
REQ-029 The first accept is possible in the first cycle with reset=0.

Verification
REQ-030 The bench drives cordic_z from a behavioral LAT-stage delay of cordic_g (identity model), with LAT=16.
REQ-031 Single request: req0 angle 20'd262144 at one edge -> cordic_g=262144 for one cycle, then 0; rsp0_valid pulses 17 edges later with rsp0_data=262144; rsp1_valid stays 0; busy high for 17 cycles.
REQ-032 Tie: both valid continuously, req0 angles 786432, 795365, ... and req1 angles 0, 67848, ... -> grant order 0,1,0,1; rsp pulses alternate with the matching angles at 1 result/cycle.
REQ-033 Streaming: req1 only, 14 consecutive angles (786432 ... 262144, 1) -> 14 consecutive rsp1 pulses in order, starting 17 cycles after the first accept.
REQ-034 Bubbles: req0 valid every other cycle with angle 131072 -> rsp0 pulses every other cycle; no pulses on bubble cycles even with the model forced to z=5.
REQ-035 Reset mid-flight: issue 5 angles, then assert reset for 1 cycle at the 3rd cycle after the last issue -> no rsp pulses follow, busy=0 after reset, and the first tie after reset grants requester 0.
